// File: rtl/avl_master_port.sv
// ---------------------------------------------------------------------------
// avl_master_port
//   CPU-side Avalon-MM master. Takes one byte/half/word load or store per
//   request, turns it into a word-aligned Avalon transfer with byteenable,
//   holds the transfer until the slave releases waitrequest, and returns the
//   load data sign- or zero-extended. Misaligned or illegal-size requests are
//   answered locally with resp_err and never reach the bus. A stall longer
//   than TIMEOUT cycles aborts the transfer with resp_err (TIMEOUT=0: never).
//
//   Handshake: a request transfers on a rising clk edge where
//   req_valid && req_ready. req_ready is high only in IDLE outside reset and
//   does not depend on req_valid. resp_valid is a one-cycle pulse with no
//   back-pressure. On the bus side a transfer completes on the first edge in
//   ACCESS with avm_waitrequest=0; avm_* outputs are held constant until then.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   req_*               CPU request (valid/ready, write, addr, size, signed, wdata)
//   resp_*              completion pulse, extended load data, error flag
//   avm_*               Avalon-MM master interface
//   dbg_state           current FSM state (0 IDLE, 1 ACCESS, 2 RESP)
// ---------------------------------------------------------------------------
module avl_master_port #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] avm_address,
  output logic [3:0]  avm_byteenable,
  output logic [31:0] avm_writedata,
  output logic        avm_read,
  output logic        avm_write,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  // Counter value on the last allowed stall edge.
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT) - 32'd1;

  state_t      state;
  logic [31:0] wait_cnt;
  logic [1:0]  size_q;
  logic        signed_q;
  logic [1:0]  off_q;

  // Request decode (IDLE side)
  logic [1:0]  req_off;
  logic        req_legal;
  logic [3:0]  req_be;
  logic [31:0] req_wdata_sh;

  // Load extraction (ACCESS side)
  logic [31:0] rd_lane;
  logic [31:0] rd_ext;

  assign req_ready    = (state == S_IDLE) && !rst;
  assign dbg_state    = state;
  assign req_off      = req_addr[1:0];
  assign req_wdata_sh = req_wdata << {req_off, 3'b000};

  always_comb begin
    req_legal = 1'b0;
    req_be    = 4'b0000;
    case (req_size)
      2'b00: begin
        req_legal = 1'b1;
        req_be    = 4'b0001 << req_off;
      end
      2'b01: begin
        req_legal = ~req_off[0];
        req_be    = req_off[1] ? 4'b1100 : 4'b0011;
      end
      2'b10: begin
        req_legal = (req_off == 2'b00);
        req_be    = 4'b1111;
      end
      default: begin
        req_legal = 1'b0;
        req_be    = 4'b0000;
      end
    endcase
  end

  always_comb begin
    rd_lane = avm_readdata >> {off_q, 3'b000};
    rd_ext  = avm_readdata;
    case (size_q)
      2'b00:   rd_ext = {{24{signed_q & rd_lane[7]}},  rd_lane[7:0]};
      2'b01:   rd_ext = {{16{signed_q & rd_lane[15]}}, rd_lane[15:0]};
      default: rd_ext = avm_readdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      wait_cnt       <= 32'd0;
      size_q         <= 2'b00;
      signed_q       <= 1'b0;
      off_q          <= 2'b00;
      resp_valid     <= 1'b0;
      resp_rdata     <= 32'd0;
      resp_err       <= 1'b0;
      avm_address    <= 32'd0;
      avm_byteenable <= 4'b0000;
      avm_writedata  <= 32'd0;
      avm_read       <= 1'b0;
      avm_write      <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            if (!req_legal) begin
              // Rejected locally: straight to the response, bus untouched.
              state      <= S_RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= 32'd0;
            end else begin
              state          <= S_ACCESS;
              avm_address    <= {req_addr[31:2], 2'b00};
              avm_byteenable <= req_be;
              avm_writedata  <= req_wdata_sh;
              avm_read       <= ~req_write;
              avm_write      <= req_write;
              size_q         <= req_size;
              signed_q       <= req_signed;
              off_q          <= req_off;
            end
          end
        end
        S_ACCESS: begin
          if (!avm_waitrequest) begin
            state      <= S_RESP;
            avm_read   <= 1'b0;
            avm_write  <= 1'b0;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            // avm_write is still the latched direction in this cycle.
            resp_rdata <= avm_write ? 32'd0 : rd_ext;
          end else if ((TIMEOUT != 0) && (wait_cnt == TO_LAST)) begin
            state      <= S_RESP;
            avm_read   <= 1'b0;
            avm_write  <= 1'b0;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            resp_rdata <= 32'd0;
          end else begin
            wait_cnt <= wait_cnt + 32'd1;
          end
        end
        S_RESP: begin
          state      <= S_IDLE;
          wait_cnt   <= 32'd0;
          resp_err   <= 1'b0;
          resp_rdata <= 32'd0;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
